// File: rtl/fd_pipe_reg_if.sv
// F/D pipeline register bus.
// Carries the fetch-side payload and pipeline controls into the register,
// and the registered decode-side view back out.
//   master : drives en/Req/M_EXLClr/EPCOut/F_*/D_BranchJump, observes D_*
//   slave  : the pipeline register itself
interface fd_pipe_reg_if #(
  parameter int STALL_CNT_W = 4
);
  logic                   en;
  logic                   Req;
  logic                   M_EXLClr;
  logic [31:0]            EPCOut;
  logic [31:0]            F_Instr;
  logic [31:0]            F_PC;
  logic [4:0]             F_ExcCode;
  logic                   D_BranchJump;
  logic [31:0]            D_Instr;
  logic [31:0]            D_PC;
  logic [4:0]             D_ExcCode;
  logic                   D_BD;
  logic                   D_Valid;
  logic [STALL_CNT_W-1:0] D_StallCnt;

  modport master (
    output en, Req, M_EXLClr, EPCOut, F_Instr, F_PC, F_ExcCode, D_BranchJump,
    input  D_Instr, D_PC, D_ExcCode, D_BD, D_Valid, D_StallCnt
  );

  modport slave (
    input  en, Req, M_EXLClr, EPCOut, F_Instr, F_PC, F_ExcCode, D_BranchJump,
    output D_Instr, D_PC, D_ExcCode, D_BD, D_Valid, D_StallCnt
  );
endinterface

// File: rtl/fd_pipe_reg.sv
// F/D pipeline register of the 5-stage MIPS core.
// Latches the fetched instruction, PC, fetch exception code and delay-slot
// flag for the D stage. Supports stall (hold), flush to a bubble on
// exception entry (Req, bubble PC = HANDLER_PC) and on eret (M_EXLClr,
// bubble PC = EPCOut), and a saturating consecutive-stall counter.
// Ports:
//   clk   - clock, all state updates on posedge
//   reset - asynchronous, active-low reset
//   bus   - fd_pipe_reg_if slave: controls, F_* inputs, registered D_* outputs
// Every output comes straight from a flop: F->D latency is one cycle.
module fd_pipe_reg #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC  = 32'h0000_4180,
  parameter int          STALL_CNT_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  fd_pipe_reg_if.slave bus
);

  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bd;
    logic        valid;
  } d_t;

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  state_t                 state_q, state_d;
  d_t                     d_q, d_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  // Priority: Req > M_EXLClr > stall > load.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    if (bus.Req) begin
      d_d     = '{instr: 32'h0, pc: HANDLER_PC, exc: 5'd0, bd: 1'b0, valid: 1'b0};
      state_d = FLUSH;
      cnt_d   = '0;
    end else if (bus.M_EXLClr) begin
      d_d     = '{instr: 32'h0, pc: bus.EPCOut, exc: 5'd0, bd: 1'b0, valid: 1'b0};
      state_d = FLUSH;
      cnt_d   = '0;
    end else if (!bus.en) begin
      state_d = HOLD;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else begin
      // A faulting fetch is delivered as a NOP so the decoder never sees
      // whatever garbage came back from the bad address.
      d_d.instr = (bus.F_ExcCode != 5'd0) ? 32'h0 : bus.F_Instr;
      d_d.pc    = bus.F_PC;
      d_d.exc   = bus.F_ExcCode;
      d_d.bd    = bus.D_BranchJump;
      d_d.valid = 1'b1;
      state_d   = RUN;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      d_q     <= '{instr: 32'h0, pc: RESET_PC, exc: 5'd0, bd: 1'b0, valid: 1'b0};
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.D_Instr    = d_q.instr;
  assign bus.D_PC       = d_q.pc;
  assign bus.D_ExcCode  = d_q.exc;
  assign bus.D_BD       = d_q.bd;
  assign bus.D_Valid    = d_q.valid;
  assign bus.D_StallCnt = cnt_q;

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Directed bench for fd_pipe_reg: a table of per-edge vectors with
// hand-computed D-side results, plus hand sequences for the long stall
// (counter saturation) and asynchronous reset in the middle of a stall.
module tb_fd_pipe_reg;

  logic clk;
  logic reset;

  fd_pipe_reg_if #(.STALL_CNT_W(4)) bus ();

  fd_pipe_reg #(
    .RESET_PC   (32'h0000_3000),
    .HANDLER_PC (32'h0000_4180),
    .STALL_CNT_W(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        req;
    logic        exl;
    logic [31:0] epc;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bj;
  } in_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bd;
    logic        valid;
    logic [3:0]  cnt;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic drive(input in_t i);
    bus.en           = i.en;
    bus.Req          = i.req;
    bus.M_EXLClr     = i.exl;
    bus.EPCOut       = i.epc;
    bus.F_Instr      = i.instr;
    bus.F_PC         = i.pc;
    bus.F_ExcCode    = i.exc;
    bus.D_BranchJump = i.bj;
  endtask

  task automatic check(input string name, input exp_t e);
    n_vec++;
    if (bus.D_Instr !== e.instr || bus.D_PC !== e.pc || bus.D_ExcCode !== e.exc ||
        bus.D_BD !== e.bd || bus.D_Valid !== e.valid || bus.D_StallCnt !== e.cnt) begin
      n_miss++;
      $display("FAIL %s: got instr=%h pc=%h exc=%0d bd=%b v=%b cnt=%0d, want instr=%h pc=%h exc=%0d bd=%b v=%b cnt=%0d",
               name, bus.D_Instr, bus.D_PC, bus.D_ExcCode, bus.D_BD, bus.D_Valid, bus.D_StallCnt,
               e.instr, e.pc, e.exc, e.bd, e.valid, e.cnt);
    end
  endtask

  vec_t vecs[15];
  exp_t rst_e;
  in_t  iv;
  exp_t ev;

  initial begin
    //                 en   req  exl  epc          instr        pc           exc  bj     instr        pc           exc  bd   v    cnt
    vecs[0]  = '{'{1'b1,1'b0,1'b0,32'h0,       32'h3C011234,32'h3000,5'd0,1'b0}, '{32'h3C011234,32'h3000,5'd0,1'b0,1'b1,4'd0}};
    vecs[1]  = '{'{1'b1,1'b0,1'b0,32'h0,       32'h24020005,32'h3004,5'd0,1'b0}, '{32'h24020005,32'h3004,5'd0,1'b0,1'b1,4'd0}};
    vecs[2]  = '{'{1'b1,1'b0,1'b0,32'h0,       32'hFFFFFFFF,32'h3002,5'd4,1'b0}, '{32'h0,       32'h3002,5'd4,1'b0,1'b1,4'd0}};
    vecs[3]  = '{'{1'b1,1'b0,1'b0,32'h0,       32'h8C030000,32'h3010,5'd0,1'b1}, '{32'h8C030000,32'h3010,5'd0,1'b1,1'b1,4'd0}};
    vecs[4]  = '{'{1'b0,1'b0,1'b0,32'h0,       32'h11111111,32'h3014,5'd0,1'b0}, '{32'h8C030000,32'h3010,5'd0,1'b1,1'b1,4'd1}};
    vecs[5]  = '{'{1'b0,1'b0,1'b0,32'h0,       32'h33333333,32'h3018,5'd4,1'b1}, '{32'h8C030000,32'h3010,5'd0,1'b1,1'b1,4'd2}};
    vecs[6]  = '{'{1'b1,1'b0,1'b0,32'h0,       32'h22222222,32'h3014,5'd0,1'b0}, '{32'h22222222,32'h3014,5'd0,1'b0,1'b1,4'd0}};
    vecs[7]  = '{'{1'b0,1'b1,1'b1,32'h3020,    32'h55555555,32'h3018,5'd4,1'b1}, '{32'h0,       32'h4180,5'd0,1'b0,1'b0,4'd0}};
    vecs[8]  = '{'{1'b1,1'b0,1'b1,32'h3020,    32'h55555555,32'h3018,5'd0,1'b1}, '{32'h0,       32'h3020,5'd0,1'b0,1'b0,4'd0}};
    vecs[9]  = '{'{1'b1,1'b1,1'b0,32'h3020,    32'h66666666,32'h301C,5'd0,1'b0}, '{32'h0,       32'h4180,5'd0,1'b0,1'b0,4'd0}};
    vecs[10] = '{'{1'b1,1'b1,1'b0,32'h0,       32'h66666666,32'h301C,5'd0,1'b0}, '{32'h0,       32'h4180,5'd0,1'b0,1'b0,4'd0}};
    vecs[11] = '{'{1'b0,1'b0,1'b0,32'h0,       32'h77777777,32'h4180,5'd0,1'b1}, '{32'h0,       32'h4180,5'd0,1'b0,1'b0,4'd1}};
    vecs[12] = '{'{1'b1,1'b0,1'b0,32'h0,       32'h40806000,32'h4180,5'd0,1'b0}, '{32'h40806000,32'h4180,5'd0,1'b0,1'b1,4'd0}};
    vecs[13] = '{'{1'b0,1'b0,1'b1,32'h3100,    32'h88888888,32'h4184,5'd0,1'b0}, '{32'h0,       32'h3100,5'd0,1'b0,1'b0,4'd0}};
    vecs[14] = '{'{1'b1,1'b0,1'b0,32'h0,       32'hAAAA5555,32'h3100,5'd0,1'b0}, '{32'hAAAA5555,32'h3100,5'd0,1'b0,1'b1,4'd0}};

    rst_e = '{32'h0, 32'h3000, 5'd0, 1'b0, 1'b0, 4'd0};

    // Reset state
    reset = 1'b0;
    drive('{1'b1, 1'b0, 1'b0, 32'h0, 32'h3C011234, 32'h3000, 5'd0, 1'b0});
    repeat (3) @(posedge clk);
    #1 check("reset", rst_e);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven edges
    for (int k = 0; k < 15; k++) begin
      drive(vecs[k].i);
      @(posedge clk);
      #1 check($sformatf("vec%0d", k), vecs[k].e);
      @(negedge clk);
    end

    // Long stall: counter saturates at 15, data holds while F_* churns
    ev = vecs[14].e;
    for (int k = 0; k < 20; k++) begin
      iv = '{1'b0, 1'b0, 1'b0, 32'h0, 32'hC0DE0000 + 32'(k), 32'h5000 + 32'(4*k), 5'(k % 2 * 4), k[0]};
      drive(iv);
      @(posedge clk);
      ev.cnt = (k + 1 > 15) ? 4'd15 : 4'(k + 1);
      #1 check($sformatf("stall%0d", k), ev);
      @(negedge clk);
    end
    drive('{1'b1, 1'b0, 1'b0, 32'h0, 32'h12345678, 32'h3200, 5'd0, 1'b1});
    @(posedge clk);
    #1 check("stall_release", '{32'h12345678, 32'h3200, 5'd0, 1'b1, 1'b1, 4'd0});
    @(negedge clk);

    // Async reset in the middle of a stall with count 5
    ev = '{32'h12345678, 32'h3200, 5'd0, 1'b1, 1'b1, 4'd0};
    drive('{1'b0, 1'b0, 1'b0, 32'h0, 32'h99999999, 32'h3300, 5'd0, 1'b0});
    repeat (5) @(posedge clk);
    ev.cnt = 4'd5;
    #1 check("pre_async_rst", ev);
    #2 reset = 1'b0;
    #1 check("async_rst", rst_e);
    @(negedge clk);
    reset = 1'b1;
    drive('{1'b1, 1'b0, 1'b0, 32'h0, 32'h3C011234, 32'h3000, 5'd0, 1'b0});
    @(posedge clk);
    #1 check("post_rst_load", '{32'h3C011234, 32'h3000, 5'd0, 1'b0, 1'b1, 4'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
